// File: rtl/shift_pipe_if.sv
// Handshake bundle for shift_pipe: operand stream in, result stream out.
// master drives operands and result-ready; slave is the shifter itself.
interface shift_pipe_if #(
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned AMT_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_amt, in_op, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_op, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter: stage k conditionally shifts by 2^k (ROL/SLL/SRA/SRL),
// with a collapsing valid/ready chain, flush and synchronous active-low reset.
module shift_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input logic          clk,
    input logic          rst_n,
    input logic          flush,
    shift_pipe_if.slave  bus
);
    localparam int unsigned AMT_W = $clog2(WIDTH);
    localparam int unsigned S     = AMT_W;

    typedef enum logic [1:0] {
        OP_ROL = 2'b00,
        OP_SLL = 2'b01,
        OP_SRA = 2'b10,
        OP_SRL = 2'b11
    } op_e;

    for (genvar k = 0; k < S; k++) begin : g_stage
        localparam int unsigned N  = 1 << k;
        // amount bits still pending at this stage's input; bit 0 is the one it consumes
        localparam int unsigned IW = AMT_W - k;

        logic             v_in;
        logic [WIDTH-1:0] d_in;
        logic [IW-1:0]    a_in;
        op_e              o_in;
        logic [WIDTH-1:0] d_sh;
        logic             ready;
        logic             valid_q;
        logic [WIDTH-1:0] data_q;

        if (k == 0) begin : g_src
            assign v_in = bus.in_valid;
            assign d_in = bus.in_data;
            assign a_in = bus.in_amt;
            assign o_in = op_e'(bus.in_op);
        end else begin : g_src
            assign v_in = g_stage[k-1].valid_q;
            assign d_in = g_stage[k-1].data_q;
            assign a_in = g_stage[k-1].g_fwd.amt_q;
            assign o_in = g_stage[k-1].g_fwd.op_q;
        end

        if (k == S - 1) begin : g_rdy
            assign ready = ~valid_q | bus.out_ready;
        end else begin : g_rdy
            assign ready = ~valid_q | g_stage[k+1].ready;
        end

        always_comb begin
            d_sh = d_in;
            if (a_in[0]) begin
                unique case (o_in)
                    OP_ROL: d_sh = {d_in[WIDTH-1-N:0], d_in[WIDTH-1:WIDTH-N]};
                    OP_SLL: d_sh = {d_in[WIDTH-1-N:0], {N{1'b0}}};
                    OP_SRA: d_sh = {{N{d_in[WIDTH-1]}}, d_in[WIDTH-1:N]};
                    OP_SRL: d_sh = {{N{1'b0}}, d_in[WIDTH-1:N]};
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (flush) begin
                valid_q <= 1'b0;
            end else if (ready) begin
                valid_q <= v_in;
                data_q  <= d_sh;
            end
        end

        // Only the not-yet-consumed amount bits and the op travel onward; the last stage needs neither.
        if (k < S - 1) begin : g_fwd
            logic [IW-2:0] amt_q;
            op_e           op_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    amt_q <= '0;
                    op_q  <= OP_ROL;
                end else if (!flush && ready) begin
                    amt_q <= a_in[IW-1:1];
                    op_q  <= o_in;
                end
            end
        end
    end

    assign bus.in_ready  = g_stage[0].ready;
    assign bus.out_valid = g_stage[S-1].valid_q;
    assign bus.out_data  = g_stage[S-1].data_q;
endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe: directed cases plus randomized traffic
// scored against a whole-amount arithmetic reference model.
module tb_shift_pipe;
    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q [$];
    logic [15:0] got_q [$];

    shift_pipe_if #(.WIDTH(16)) b16 ();
    shift_pipe_if #(.WIDTH(32)) b32 ();

    shift_pipe #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b16.slave));
    shift_pipe #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Shift by the full amount at once, straight from the op definitions.
    function automatic logic [63:0] ref_shift(input int unsigned w, input logic [63:0] x,
                                              input int unsigned a, input logic [1:0] op);
        logic [63:0] mask;
        logic [63:0] v;
        logic [63:0] r;
        mask = (64'd1 << w) - 64'd1;
        v = x & mask;
        case (op)
            2'b00:   r = (a == 0) ? v : ((v << a) | (v >> (w - a)));
            2'b01:   r = v << a;
            2'b10:   r = v[w-1] ? ((v >> a) | ~(mask >> a)) : (v >> a);
            default: r = v >> a;
        endcase
        return r & mask;
    endfunction

    // Scoreboard: evaluated mid-cycle, i.e. describes the coming rising edge.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            exp_q.delete();
        end else begin
            if (b16.out_valid && b16.out_ready) begin
                got_q.push_back(b16.out_data);
                if (exp_q.size() == 0) check("sb_spurious", 1'b1, 1'b0);
                else check("sb_data", b16.out_data, exp_q.pop_front());
            end
            if (b16.in_valid && b16.in_ready)
                exp_q.push_back(16'(ref_shift(16, b16.in_data, b16.in_amt, b16.in_op)));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set16(input logic [15:0] d, input logic [3:0] a, input logic [1:0] op);
        b16.in_valid = 1'b1;
        b16.in_data  = d;
        b16.in_amt   = a;
        b16.in_op    = op;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && (exp_q.size() != 0 || b16.out_valid); i++) step();
        check(tag, exp_q.size(), 0);
    endtask

    logic [15:0] t1_exp [4] = '{16'h0018, 16'h0010, 16'hF800, 16'h0800};
    logic [15:0] t2_din [4] = '{16'h8000, 16'h8000, 16'h0001, 16'h1234};
    logic [3:0]  t2_amt [4] = '{4'd15, 4'd15, 4'd15, 4'd0};
    logic [1:0]  t2_op  [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    logic [15:0] t2_exp [4] = '{16'hFFFF, 16'h0001, 16'h8000, 16'h1234};

    initial begin
        int idx;
        logic acc;
        rst_n = 1'b0;
        flush = 1'b0;
        b16.in_valid = 1'b0; b16.in_data = '0; b16.in_amt = '0; b16.in_op = '0; b16.out_ready = 1'b1;
        b32.in_valid = 1'b0; b32.in_data = '0; b32.in_amt = '0; b32.in_op = '0; b32.out_ready = 1'b1;
        step();
        step();
        check("rst_in_ready", b16.in_ready, 1'b1);
        check("rst_out_valid", b16.out_valid, 1'b0);
        check("rst_out_data", b16.out_data, 16'h0);
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", b16.in_ready, 1'b1);

        // Four ops back-to-back on 0x8001 amt 4; first result visible after the 4th accept edge.
        for (int i = 0; i < 4; i++) begin
            set16(16'h8001, 4'd4, 2'(i));
            step();
            check("t1_latency", b16.out_valid, i == 3);
        end
        b16.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t1_valid", b16.out_valid, 1'b1);
            check("t1_data", b16.out_data, t1_exp[i]);
            step();
        end
        drain("t1_drain");

        got_q.delete();
        for (int i = 0; i < 4; i++) begin
            set16(t2_din[i], t2_amt[i], t2_op[i]);
            step();
        end
        b16.in_valid = 1'b0;
        drain("t2_drain");
        check("t2_count", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) check("t2_edge", got_q[i], t2_exp[i]);

        // Backpressure: six distinct ops against a stalled consumer.
        got_q.delete();
        b16.out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            set16(16'h1111 * 16'(idx + 1), 4'(idx + 1), 2'(idx));
            #1 acc = b16.in_ready;
            step();
            if (acc) idx++;
        end
        check("bp_accepted", idx, 4);
        check("bp_in_ready", b16.in_ready, 1'b0);
        check("bp_out_valid", b16.out_valid, 1'b1);
        check("bp_head", b16.out_data, ref_shift(16, 16'h1111, 1, 2'b00));
        step();
        check("bp_hold", b16.out_data, ref_shift(16, 16'h1111, 1, 2'b00));
        b16.out_ready = 1'b1;
        #1 check("bp_ready_full", b16.in_ready, 1'b1);
        for (int c = 0; c < 20 && idx < 6; c++) begin
            set16(16'h1111 * 16'(idx + 1), 4'(idx + 1), 2'(idx));
            #1 acc = b16.in_ready;
            step();
            if (acc) idx++;
        end
        b16.in_valid = 1'b0;
        drain("bp_drain");
        check("bp_count", got_q.size(), 6);

        // Flush with three ops in flight and a fourth presented alongside it.
        got_q.delete();
        for (int i = 0; i < 3; i++) begin
            set16(16'hA5A5, 4'(i + 1), 2'(i));
            step();
        end
        set16(16'h5A5A, 4'd2, 2'b01);
        flush = 1'b1;
        step();
        flush = 1'b0;
        b16.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("fl_out_valid", b16.out_valid, 1'b0);
            step();
        end
        check("fl_count", got_q.size(), 0);

        // Reset mid-flight with a full pipe.
        b16.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set16(16'hC3C3, 4'(i), 2'(i));
            step();
        end
        b16.in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rs_out_valid", b16.out_valid, 1'b0);
        check("rs_out_data", b16.out_data, 16'h0);
        check("rs_in_ready", b16.in_ready, 1'b1);
        got_q.delete();
        b16.out_ready = 1'b1;
        set16(16'h00F0, 4'd4, 2'b11);
        step();
        b16.in_valid = 1'b0;
        drain("rs_drain");
        check("rs_count", got_q.size(), 1);
        if (got_q.size() > 0) check("rs_data", got_q[0], 16'h000F);

        // Randomized traffic with stalls and rare flushes.
        for (int n = 0; n < 400; n++) begin
            set16(16'($urandom), 4'($urandom), 2'($urandom));
            b16.in_valid  = ($urandom_range(3) != 0);
            flush         = ($urandom_range(99) == 0);
            b16.out_ready = flush ? 1'b0 : ($urandom_range(9) < 7);
            step();
        end
        flush = 1'b0;
        b16.in_valid = 1'b0;
        b16.out_ready = 1'b1;
        drain("rnd_drain");

        // WIDTH = 32: five stages.
        b32.in_valid = 1'b1; b32.in_data = 32'h80000001; b32.in_amt = 5'd31; b32.in_op = 2'b00;
        for (int i = 0; i < 5; i++) begin
            step();
            b32.in_valid = 1'b0;
            check("w32_latency", b32.out_valid, i == 4);
        end
        check("w32_rol", b32.out_data, 32'hC0000000);
        b32.in_valid = 1'b1; b32.in_data = 32'h80000000; b32.in_amt = 5'd31; b32.in_op = 2'b10;
        for (int i = 0; i < 5; i++) begin
            step();
            b32.in_valid = 1'b0;
        end
        check("w32_sra_valid", b32.out_valid, 1'b1);
        check("w32_sra", b32.out_data, 32'hFFFFFFFF);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_pipe.md
# shift_pipe

Parametrised, pipelined barrel shifter with valid/ready handshakes, the next generation of the single-stage shift-by-4 cell in the ALU shifter. It takes a WIDTH-bit operand, a shift amount and a 2-bit op, and performs the shift as log2(WIDTH) registered stages. Stage k shifts by 2^k. The block sustains one result per cycle, supports backpressure and flush, and sits between the execute-stage operand muxes and the result bus.

## Interface
- WIDTH, 16, operand width; power of 2, 4 to 64.
- AMT_W, $clog2(WIDTH), shift-amount width and stage count S; derived, never overridden.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush  in  1  discards all in-flight operations.
- in_valid  in  1  an operation is presented.
- in_ready  out  1  the block accepts the operation this cycle.
- in_data  in  WIDTH  operand.
- in_amt  in  AMT_W  shift amount, 0 to WIDTH-1.
- in_op  in  2  00 ROL, 01 SLL, 10 SRA, 11 SRL.
- out_valid  out  1  a result is presented.
- out_ready  in  1  the consumer takes the result this cycle.
- out_data  out  WIDTH  result of stage S-1.

## Operation
- Stages 0..S-1. Each stage holds these registers: valid_k, data_k, amt_k, op_k.
- Stage k combinationally shifts its input by 2^k when amt bit k = 1; otherwise it passes the input through. The result is registered into stage k.
- Stage 0's input is in_data, in_amt and in_op. Stage k's input is stage k-1's registers.
- Shift-by-2^k rule for n = 2^k:
  - ROL: bit i ← bit (i−n) mod WIDTH.
  - SLL: bit i ← bit i−n; zeros fill the low n bits.
  - SRA: bit i ← bit i+n; the current MSB fills the top n bits.
  - SRL: bit i ← bit i+n; zeros fill the top n bits.
- SRA needs no separately carried sign. After an SRA stage the MSB still equals the original sign.
- Ready chain: ready_S = out_ready; ready_k = ~valid_k | ready_(k+1); in_ready = ready_0.
  - in_ready is combinational from out_ready. This path is accepted.
- Stage k loads when ready_k = 1:
  - stage 0: valid_0 ← in_valid;
  - stage k > 0: valid_k ← valid_(k-1).
  - data, amt and op load together with valid.
- A stage with ready_k = 0 holds all of its registers.
- The bubbles in the chain collapse under backpressure. Capacity is S operations.
- out_valid = valid_(S-1); out_data = data_(S-1).
- flush = 1 at an edge:
  - all valid_k ← 0 and nothing is accepted;
  - in_ready still reads as computed, but the handshake is void;
  - flush has priority over acceptance.
- rst_n = 0 at an edge: all valid_k ← 0, all data/amt/op ← 0. rst_n has priority over flush.
- Reset values: out_valid = 0, out_data = 0; in_ready = 1 during and after reset.
- Amount 0: result equals the operand for every op.

## Timing
- Accept on edge t (in_valid & in_ready). With no backpressure, out_valid = 1 in the cycle after edge t+S-1, i.e. latency S cycles. For WIDTH = 16 that is 4 cycles.
- Throughput: one accept per cycle while out_ready = 1.
- out_ready low:
  - out_data and out_valid are held stable;
  - upstream stages keep filling until all S are valid, then in_ready = 0.
- out_ready high with all stages full: in_ready = 1 in the same cycle. A simultaneous accept and emit occurs with no bubble.
- Reset mid-operation: on the first edge with rst_n = 0, every in-flight op is lost. No result emerges afterwards.

## Test plan
- WIDTH = 16, in_data = 0x8001, amt = 4, ops 00/01/10/11 back-to-back:
  - out_data = 0x0018, 0x0010, 0xF800, 0x0800 on 4 consecutive cycles;
  - first result 4 cycles after the first accept.
- Edge amounts, WIDTH = 16:
  - SRA 0x8000 amt 15 → 0xFFFF; SRL 0x8000 amt 15 → 0x0001;
  - SLL 0x0001 amt 15 → 0x8000; ROL 0x1234 amt 0 → 0x1234.
- Backpressure: out_ready = 0, in_valid held high with 6 distinct ops.
  - Exactly 4 are accepted, then in_ready = 0.
  - Raising out_ready drains them in order, one per cycle, with no loss or duplication.
  - Ops 5 and 6 are accepted as slots free.
- Flush: 3 ops in flight, flush pulsed 1 cycle together with in_valid.
  - The next cycle out_valid = 0 and stays 0.
  - The op presented with flush is not emitted.
- Reset: rst_n low 1 cycle while 4 ops are in flight.
  - out_valid = 0, out_data = 0 afterwards.
  - in_ready = 1; a new op is processed normally.
- WIDTH = 32 (S = 5): ROL 0x80000001 amt 31 → 0xC0000000; SRA 0x80000000 amt 31 → 0xFFFFFFFF; latency 5 cycles.
